// File: rtl/dac_pkg.sv
// ============================================================================
// Module   : dac_pkg
// Brief    : Frame constants and receiver FSM states shared by the DAC driver
//            and the frame receiver.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dac_pkg;

   localparam int          FRAME_BITS = 32;
   localparam int          CODE_W     = 12;
   localparam logic [31:0] SETUP_WORD = 32'h0800_0001;
   localparam logic [11:0] CMD_PREFIX = 12'h030;

   typedef enum logic [1:0] {
      SYNC  = 2'd0,
      IDLE  = 2'd1,
      SHIFT = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/dac_frame_decode.sv
// ============================================================================
// Module   : dac_frame_decode
// Brief    : Combinational classifier of a received frame (word, bit count)
//            into setup / data / length-error / command-error, plus code field.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dac_frame_decode #(
   parameter int                FRAME_BITS = 32,
   parameter int                CODE_W     = 12,
   parameter int                CNT_W      = 6,
   parameter logic [31:0]       SETUP_WORD = 32'h0800_0001,
   parameter logic [11:0]       CMD_PREFIX = 12'h030
) (
   input  logic [FRAME_BITS-1:0] word,
   input  logic [CNT_W-1:0]      count,
   output logic                  is_setup,
   output logic                  is_data,
   output logic                  len_bad,
   output logic                  cmd_bad,
   output logic [CODE_W-1:0]     code
);

   // Frame layout: prefix in the top 12 bits, code below it, reserved low field.
   localparam int               LOW_W  = FRAME_BITS - 12 - CODE_W;
   localparam logic [CNT_W-1:0] c_full = CNT_W'(FRAME_BITS);

   logic w_prefix_ok;
   logic w_low_zero;

   always_comb begin
      w_prefix_ok = (word[FRAME_BITS-1 -: 12] == CMD_PREFIX);
      w_low_zero  = (word[LOW_W-1:0] == '0);
      len_bad     = (count != c_full);
      is_setup    = !len_bad && (word == FRAME_BITS'(SETUP_WORD));
      is_data     = !len_bad && !is_setup && w_prefix_ok && w_low_zero;
      cmd_bad     = !len_bad && !is_setup && !is_data;
      code        = word[LOW_W +: CODE_W];
   end

endmodule

`default_nettype wire

// File: rtl/dac_frame_rx.sv
// ============================================================================
// Module   : dac_frame_rx
// Brief    : Deserialises cs/mosi frames from the DAC driver, tracks setup,
//            delivers DAC codes on valid/ready and flags malformed traffic.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dac_frame_rx #(
   parameter int          FRAME_BITS = dac_pkg::FRAME_BITS,
   parameter logic [31:0] SETUP_WORD = dac_pkg::SETUP_WORD,
   parameter logic [11:0] CMD_PREFIX = dac_pkg::CMD_PREFIX,
   parameter int          CODE_W     = dac_pkg::CODE_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cs,
   input  logic                  mosi,
   output logic [CODE_W-1:0]     code,
   output logic                  code_valid,
   input  logic                  code_ready,
   output logic                  configured,
   output logic [FRAME_BITS-1:0] frame_word,
   output logic                  frame_done,
   output logic                  err_len,
   output logic                  err_cmd,
   output logic                  err_seq,
   output logic                  overrun
);

   import dac_pkg::*;

   // Counter saturates at FRAME_BITS+1 so long frames stay distinguishable.
   localparam int               CNT_W  = $clog2(FRAME_BITS + 2);
   localparam logic [CNT_W-1:0] c_full = CNT_W'(FRAME_BITS);

   state_t                r_state;
   state_t                w_next;
   logic [FRAME_BITS-1:0] r_shreg;
   logic [CNT_W-1:0]      r_count;
   logic                  w_first;
   logic                  w_shift;
   logic                  w_decode;
   logic                  w_is_setup;
   logic                  w_is_data;
   logic                  w_len_bad;
   logic                  w_cmd_bad;
   logic [CODE_W-1:0]     w_code;
   logic                  w_blocked;
   logic                  w_data_ok;

   dac_frame_decode #(
      .FRAME_BITS (FRAME_BITS),
      .CODE_W     (CODE_W),
      .CNT_W      (CNT_W),
      .SETUP_WORD (SETUP_WORD),
      .CMD_PREFIX (CMD_PREFIX)
   ) u_decode (
      .word     (r_shreg),
      .count    (r_count),
      .is_setup (w_is_setup),
      .is_data  (w_is_data),
      .len_bad  (w_len_bad),
      .cmd_bad  (w_cmd_bad),
      .code     (w_code)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= SYNC;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_first  = 1'b0;
      w_shift  = 1'b0;
      w_decode = 1'b0;
      case (r_state)
         SYNC:  if (cs) w_next = IDLE;
         IDLE:  if (!cs) begin
                   w_first = 1'b1;
                   w_next  = SHIFT;
                end
         SHIFT: if (cs) begin
                   w_decode = 1'b1;
                   w_next   = IDLE;
                end else begin
                   w_shift = 1'b1;
                end
         default: w_next = SYNC;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shreg <= '0;
         r_count <= '0;
      end else if (w_first) begin
         r_shreg <= FRAME_BITS'(mosi);
         r_count <= CNT_W'(1);
      end else if (w_shift) begin
         if (r_count < c_full)
            r_shreg <= {r_shreg[FRAME_BITS-2:0], mosi};
         if (r_count <= c_full)
            r_count <= r_count + CNT_W'(1);
      end
   end

   always_comb begin
      w_blocked = code_valid && !code_ready;
      w_data_ok = w_decode && w_is_data && configured;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code       <= '0;
         code_valid <= 1'b0;
         configured <= 1'b0;
         frame_word <= '0;
         frame_done <= 1'b0;
         err_len    <= 1'b0;
         err_cmd    <= 1'b0;
         err_seq    <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         frame_done <= w_decode;
         err_len    <= w_decode && w_len_bad;
         err_cmd    <= w_decode && w_cmd_bad;
         err_seq    <= w_decode && w_is_data && !configured;
         overrun    <= w_data_ok && w_blocked;
         if (w_decode)
            frame_word <= r_shreg;
         if (w_decode && w_is_setup)
            configured <= 1'b1;
         // A load on the accepting edge keeps valid high with the fresh code.
         if (w_data_ok && !w_blocked) begin
            code       <= w_code;
            code_valid <= 1'b1;
         end else if (code_valid && code_ready) begin
            code_valid <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dac_frame_rx.sv
// ============================================================================
// Module   : tb_dac_frame_rx
// Brief    : Directed self-checking bench for the DAC frame receiver.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dac_frame_rx;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cs;
   logic        mosi;
   logic [11:0] code;
   logic        code_valid;
   logic        code_ready;
   logic        configured;
   logic [31:0] frame_word;
   logic        frame_done;
   logic        err_len;
   logic        err_cmd;
   logic        err_seq;
   logic        overrun;

   int passed = 0;
   int total  = 0;

   dac_frame_rx dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cs         (cs),
      .mosi       (mosi),
      .code       (code),
      .code_valid (code_valid),
      .code_ready (code_ready),
      .configured (configured),
      .frame_word (frame_word),
      .frame_done (frame_done),
      .err_len    (err_len),
      .err_cmd    (err_cmd),
      .err_seq    (err_seq),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Drives n bits MSB first on negedges, then one cs-high cycle; returns at
   // the negedge where the decode results are visible.
   task automatic send_frame(input logic [63:0] w, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cs   = 1'b0;
         mosi = w[n-1-i];
      end
      @(negedge clk);
      cs   = 1'b1;
      mosi = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst_n      = 1'b0;
      cs         = 1'b1;
      mosi       = 1'b0;
      code_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_code_valid", 32'(code_valid), 32'd0);
      chk("rst_configured", 32'(configured), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk("rst_code",       32'(code),       32'd0);
      chk("rst_frame_word", frame_word,      32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Data before setup
      send_frame(64'h0301_2300, 32);
      chk("seq_err_seq",    32'(err_seq),    32'd1);
      chk("seq_valid",      32'(code_valid), 32'd0);
      chk("seq_word",       frame_word,      32'h0301_2300);
      chk("seq_done",       32'(frame_done), 32'd1);
      chk("seq_cfg",        32'(configured), 32'd0);

      // Setup then data ABC
      send_frame(64'h0800_0001, 32);
      chk("setup_cfg",      32'(configured), 32'd1);
      chk("setup_done",     32'(frame_done), 32'd1);
      chk("setup_err_cmd",  32'(err_cmd),    32'd0);
      send_frame(64'h030A_BC00, 32);
      chk("abc_code",       32'(code),       32'h0000_0ABC);
      chk("abc_valid",      32'(code_valid), 32'd1);
      chk("abc_done",       32'(frame_done), 32'd1);
      chk("abc_err_seq",    32'(err_seq),    32'd0);
      @(negedge clk);
      chk("abc_accepted",   32'(code_valid), 32'd0);
      chk("abc_done_pulse", 32'(frame_done), 32'd0);

      // Short and long frames
      send_frame(64'h0800_0001, 31);
      chk("short_err_len",  32'(err_len),    32'd1);
      chk("short_cfg",      32'(configured), 32'd1);
      chk("short_code",     32'(code),       32'h0000_0ABC);
      send_frame(64'h1_0800_0001, 33);
      chk("long_err_len",   32'(err_len),    32'd1);
      chk("long_word",      frame_word,      32'h8400_0000);
      chk("long_code",      32'(code),       32'h0000_0ABC);
      chk("long_err_cmd",   32'(err_cmd),    32'd0);

      // Malformed commands
      send_frame(64'h0400_1200, 32);
      chk("cmd_prefix",     32'(err_cmd),    32'd1);
      chk("cmd_prefix_len", 32'(err_len),    32'd0);
      send_frame(64'h030F_FF01, 32);
      chk("cmd_lowbyte",    32'(err_cmd),    32'd1);
      chk("cmd_lowbyte_v",  32'(code_valid), 32'd0);
      chk("cmd_lowbyte_c",  32'(code),       32'h0000_0ABC);

      // Back-pressure and overrun
      code_ready = 1'b0;
      send_frame(64'h0301_1100, 32);
      chk("bp1_code",       32'(code),       32'h0000_0111);
      chk("bp1_valid",      32'(code_valid), 32'd1);
      chk("bp1_overrun",    32'(overrun),    32'd0);
      send_frame(64'h0302_2200, 32);
      chk("bp2_overrun",    32'(overrun),    32'd1);
      chk("bp2_code",       32'(code),       32'h0000_0111);
      chk("bp2_valid",      32'(code_valid), 32'd1);
      @(negedge clk);
      chk("bp_hold_code",   32'(code),       32'h0000_0111);
      chk("bp_ovr_pulse",   32'(overrun),    32'd0);
      code_ready = 1'b1;
      @(negedge clk);
      chk("bp_release",     32'(code_valid), 32'd0);

      // Reset in the middle of a frame, released while cs still low
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         cs   = 1'b0;
         mosi = i[0];
      end
      rst_n = 1'b0;
      #1;
      chk("mid_rst_cfg",    32'(configured), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 21; i++) begin
         @(negedge clk);
         cs   = 1'b0;
         mosi = i[1];
      end
      @(negedge clk);
      cs   = 1'b1;
      mosi = 1'b0;
      @(negedge clk);
      chk("mid_done",       32'(frame_done), 32'd0);
      chk("mid_err_len",    32'(err_len),    32'd0);
      send_frame(64'h0800_0001, 32);
      chk("post_done",      32'(frame_done), 32'd1);
      chk("post_cfg",       32'(configured), 32'd1);
      chk("post_word",      frame_word,      32'h0800_0001);
      chk("post_err_len",   32'(err_len),    32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dac_frame_rx.md
Name: dac_frame_rx

Overview:
- Receive-side stage that sits directly downstream of the DAC serial driver. It consumes the driver's cs/mosi pair on the same clk; there is no separate serial clock.
- Deserialises 32-bit frames, recognises the setup word, and checks data frames for the DAC command format.
- Delivers the 12-bit DAC code on a valid/ready interface for checking or monitoring logic, and flags malformed traffic.

Parameters:
- FRAME_BITS, 32, bits per frame.
- SETUP_WORD, 32'h0800_0001, configuration frame value.
- CMD_PREFIX, 12'h030, required value of frame[31:20] in a data frame.
- CODE_W, 12, DAC code width, taken from frame[19:8].

Ports:
- clk  in  1  system clock; all sampling on posedge.
- rst_n  in  1  asynchronous active-low reset.
- cs  in  1  frame select, active low, driven by the DAC driver on clk.
- mosi  in  1  serial data, MSB first, valid on every edge where cs=0.
- code  out  CODE_W  decoded DAC code.
- code_valid  out  1  code available; held until accepted.
- code_ready  in  1  consumer accepts code when code_valid & code_ready.
- configured  out  1  sticky; set by a good setup frame.
- frame_word  out  FRAME_BITS  last complete frame, any type.
- frame_done  out  1  one-cycle pulse per terminated frame.
- err_len  out  1  pulse: frame bit count was not FRAME_BITS.
- err_cmd  out  1  pulse: 32-bit frame is neither setup nor a well-formed data frame.
- err_seq  out  1  pulse: well-formed data frame received while configured=0.
- overrun  out  1  pulse: new code dropped because code_valid was still set.

Behaviour:
- Reset (async assert, sync release):
  - All outputs go to 0; shift register and bit counter clear; FSM goes to SYNC.
- FSM states:
  - SYNC: wait for cs=1, then go to IDLE. This discards a partial frame when reset is released mid-frame.
  - IDLE: on cs=0, shift in mosi, set count=1, go to SHIFT.
  - SHIFT, cs=0: shift mosi into the LSB, MSB first. count increments and saturates at FRAME_BITS+1. Bits beyond FRAME_BITS are ignored and the frame is marked long.
  - SHIFT, cs=1: end of frame. Decode, then go to IDLE.
- Decode, registered on the edge that samples cs=1 (outputs visible one cycle after cs rises):
  - frame_done=1 and frame_word=shift register, always.
  - If count != FRAME_BITS: err_len=1 and no further decode.
  - Else if word == SETUP_WORD: configured<=1. A repeated setup word is legal and has no other effect.
  - Else if word[31:20]==CMD_PREFIX and word[7:0]==0:
    - If configured=0: err_seq=1 and the code is discarded.
    - Else if code_valid=1 and code_ready=0 on this edge: overrun=1, and the old code is kept.
    - Else: code<=word[19:8] and code_valid<=1.
  - Otherwise: err_cmd=1.
- Handshake:
  - code_valid clears on code_valid & code_ready, unless a new code is loaded on the same edge. In that case the new code is loaded and code_valid stays 1.
  - code must not change while code_valid=1 and code_ready=0.
- Back-to-back frames: a single cs-high cycle between frames is sufficient. IDLE accepts cs=0 on the cycle after the decode edge.
- A frame of 0 bits cannot occur, because SHIFT is only entered with count=1.
- configured is cleared only by rst_n.

Decomposition:
- Shared package dac_pkg holds the FSM state enum (SYNC, IDLE, SHIFT) and the constants SETUP_WORD, CMD_PREFIX, FRAME_BITS, CODE_W. The DAC driver uses the same constants from this package.
- One natural sub-module, dac_frame_decode: a combinational classifier from (word, count) to {is_setup, is_data, len_bad, cmd_bad} plus the code field.
- The top level holds the FSM, shift register and handshake register.

Test Plan:
- Reset release, then the setup frame 32'h0800_0001 followed by a data frame with din=12'hABC (word 32'h030A_BC00) -> configured=1 after the first frame; code=12'hABC and code_valid=1 one cycle after cs rises; frame_done pulses twice.
- Data frame 32'h0301_2300 before any setup -> err_seq=1, code_valid stays 0, frame_word=32'h0301_2300.
- cs low for 31 bits, then 33 bits -> err_len pulses each time; configured and code are unchanged.
- Frame 32'h0400_1200 after setup -> err_cmd=1; frame 32'h030F_FF01 (low byte nonzero) -> err_cmd=1.
- code_ready=0 while two data frames (12'h111, then 12'h222) arrive -> code stays 12'h111 and overrun pulses on the second frame. Then raise code_ready -> code_valid clears the next cycle.
- Assert rst_n low at bit 10 of a frame and release while cs is still low -> no err_len and no frame_done for that frame; the next full setup frame decodes normally.
